// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl
//   Sequences the multi-cycle multiplier/divider from the execute stage.
//   It accepts one mult/div op and holds its operands stable. It pulses the
//   unit's start line and stalls the pipeline until the result is ready. It
//   then issues a single register-file writeback: the result goes to rd, or
//   the status code goes to STATUS_REG on exception. A watchdog forces an
//   exception if the unit never signals ready.
// Ports
//   clock, reset                 : clock; synchronous active-high reset
//   issue_valid/is_div/rd/opA/opB: op offered by the X stage
//   md_result/exception/resultRDY/status : responses from the unit
//   ctrl_MULT, ctrl_DIV          : one-cycle start pulses to the unit
//   md_opA, md_opB               : latched operands driven to the unit
//   stall, busy, pend_rd         : pipeline control and hazard info
//   wb_valid, wb_rd, wb_data     : one-cycle register-file write
//   timeout                      : sticky watchdog flag
module multdiv_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [4:0]  STATUS_REG     = 5'd30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  input  logic [31:0] md_status,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        stall,
  output logic        busy,
  output logic [4:0]  pend_rd,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_e;

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic          is_div_q, is_div_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   opa_q, opa_d;
  logic [31:0]   opb_q, opb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   res_q, res_d;
  logic          exc_q, exc_d;
  logic [31:0]   status_q, status_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    rd_d      = rd_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    exc_d     = exc_q;
    status_d  = status_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue_valid) begin
          is_div_d = issue_is_div;
          rd_d     = issue_rd;
          opa_d    = issue_opA;
          opb_d    = issue_opB;
          state_d  = S_START;
        end
      end
      S_START: begin
        // Any ready seen here belongs to a previous op and is ignored.
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A real ready takes priority over watchdog expiry in the same cycle.
        if (md_resultRDY) begin
          res_d    = md_result;
          exc_d    = md_exception;
          status_d = md_status;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          exc_d     = 1'b1;
          status_d  = is_div_q ? 32'd5 : 32'd4;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      rd_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      exc_q     <= 1'b0;
      status_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      rd_q      <= rd_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      exc_q     <= exc_d;
      status_q  <= status_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    ctrl_MULT = (state_q == S_START) && !is_div_q;
    ctrl_DIV  = (state_q == S_START) && is_div_q;
    md_opA    = opa_q;
    md_opB    = opb_q;
    busy      = (state_q != S_IDLE);
    pend_rd   = busy ? rd_q : '0;
    // Stall is combinational in IDLE so the op is held during its accept
    // cycle. It is released in DONE so the instruction leaves X.
    stall     = (state_q == S_IDLE) ? issue_valid : (state_q != S_DONE);
    wb_valid  = (state_q == S_DONE) && (exc_q || (rd_q != '0));
    wb_rd     = '0;
    wb_data   = '0;
    if (state_q == S_DONE) begin
      wb_rd   = exc_q ? STATUS_REG : rd_q;
      wb_data = exc_q ? status_q : res_q;
    end
    timeout   = timeout_q;
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
module tb_multdiv_issue_ctrl;

  localparam int TO = 64;

  logic        clock, reset;
  logic        issue_valid, issue_is_div;
  logic [4:0]  issue_rd;
  logic [31:0] issue_opA, issue_opB;
  logic [31:0] md_result, md_status;
  logic        md_exception, md_resultRDY;
  logic        ctrl_MULT, ctrl_DIV, stall, busy, wb_valid, timeout;
  logic [31:0] md_opA, md_opB, wb_data;
  logic [4:0]  pend_rd, wb_rd;

  multdiv_issue_ctrl #(.TIMEOUT_CYCLES(TO), .STATUS_REG(5'd30)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
    .issue_opA(issue_opA), .issue_opB(issue_opB),
    .md_result(md_result), .md_exception(md_exception),
    .md_resultRDY(md_resultRDY), .md_status(md_status),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .md_opA(md_opA), .md_opB(md_opB),
    .stall(stall), .busy(busy), .pend_rd(pend_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // One op as seen on the timeline: accept cycle, final cycle (DONE, or
  // the reset cycle if aborted) and what the writeback must carry.
  typedef struct {
    int          a;
    int          fin;
    bit          aborted;
    bit          is_div;
    logic [4:0]  rd;
    logic [31:0] opa, opb;
    bit          exc;
    logic [31:0] wbd;
    bit          to;
  } op_t;

  typedef struct {
    int          c;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  op_t ops[$];
  int  rst_cyc[$];
  wb_t wb_log[$];
  int  mult_pulses = 0;
  bit  run_done = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  function automatic bit reset_in(input int lo, input int hi);
    foreach (rst_cyc[i]) if (rst_cyc[i] >= lo && rst_cyc[i] <= hi) return 1;
    return 0;
  endfunction

  // Expected outputs at cycle c from the op timeline.
  always @(negedge clock) begin
    if (cyc >= 1 && !run_done) begin
      bit          e_mult, e_div, e_stall, e_busy, e_wbv, e_to;
      logic [4:0]  e_pend, e_wbrd;
      logic [31:0] e_opa, e_opb, e_wbd;
      e_mult = 0; e_div = 0; e_stall = 0; e_busy = 0; e_wbv = 0; e_to = 0;
      e_pend = '0; e_wbrd = '0; e_opa = '0; e_opb = '0; e_wbd = '0;
      foreach (ops[i]) begin
        op_t o;
        o = ops[i];
        if (cyc >= o.a && cyc <= o.fin) begin
          if (cyc == o.a) e_stall = 1;
          else begin
            e_busy = 1;
            e_pend = o.rd;
            if (cyc == o.a + 1) begin
              e_mult = !o.is_div; e_div = o.is_div; e_stall = 1;
            end else if (cyc == o.fin && !o.aborted) begin
              e_wbv  = o.exc || (o.rd != 0);
              e_wbrd = o.exc ? 5'd30 : o.rd;
              e_wbd  = o.wbd;
            end else e_stall = 1;
          end
        end
        if (o.a < cyc && !reset_in(o.a, cyc - 1)) begin
          e_opa = o.opa; e_opb = o.opb;
        end
        if (o.to && !o.aborted && o.fin <= cyc && !reset_in(o.fin, cyc - 1)) e_to = 1;
      end
      chk("ctrl_MULT", 32'(ctrl_MULT), 32'(e_mult));
      chk("ctrl_DIV", 32'(ctrl_DIV), 32'(e_div));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("pend_rd", 32'(pend_rd), 32'(e_pend));
      chk("md_opA", md_opA, e_opa);
      chk("md_opB", md_opB, e_opb);
      chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
      chk("timeout", 32'(timeout), 32'(e_to));
      if (e_wbv) begin
        chk("wb_rd", 32'(wb_rd), 32'(e_wbrd));
        chk("wb_data", wb_data, e_wbd);
      end
      if (wb_valid) wb_log.push_back('{c: cyc, rd: wb_rd, data: wb_data});
      if (ctrl_MULT) mult_pulses++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 0; issue_is_div = 0; issue_rd = '0;
    issue_opA = '0; issue_opB = '0;
    md_result = '0; md_exception = 0; md_resultRDY = 0; md_status = '0;
  endtask

  // k = cycles after START at which ready arrives; k < 0 means never.
  task automatic run_op(input bit dv, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int k, input logic [31:0] res,
                        input bit exc, input logic [31:0] st, input bit stale,
                        input bit hold_done);
    op_t o;
    o.a = cyc; o.aborted = 0; o.is_div = dv; o.rd = rd; o.opa = a; o.opb = b;
    o.to  = (k < 0);
    o.exc = exc || o.to;
    o.wbd = o.to ? (dv ? 32'd5 : 32'd4) : (exc ? st : res);
    o.fin = o.to ? o.a + 2 + TO : o.a + k + 2;
    ops.push_back(o);
    issue_valid = 1; issue_is_div = dv; issue_rd = rd; issue_opA = a; issue_opB = b;
    step();
    issue_valid = 0; issue_opA = 32'hBAD0BAD0; issue_opB = 32'h0BAD0BAD;
    if (stale) begin
      md_resultRDY = 1; md_result = 32'hDEAD; md_exception = 1; md_status = 32'd4;
    end
    while (cyc < o.fin) begin
      step();
      md_resultRDY = (k > 0) && (cyc == o.a + 1 + k);
      md_result    = md_resultRDY ? res : '0;
      md_exception = md_resultRDY && exc;
      md_status    = md_resultRDY ? st : '0;
      if (hold_done && cyc == o.fin) begin
        issue_valid = 1; issue_is_div = dv; issue_rd = rd; issue_opA = a; issue_opB = b;
      end
    end
    step();
    clear_inputs();
  endtask

  initial begin
    int n0, a0;
    clear_inputs();
    reset = 1;
    rst_cyc.push_back(0);
    step();
    rst_cyc.push_back(1);
    step();
    reset = 0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    chk("reset_opA", md_opA, 32'd0);

    // mult 7 * -6, rd=3, ready 17 cycles after START
    n0 = wb_log.size(); a0 = cyc;
    run_op(0, 5'd3, 32'd7, -32'sd6, 17, 32'(32'sd7 * -32'sd6), 0, 0, 0, 0);
    chk("mult_wb_count", 32'(wb_log.size() - n0), 32'd1);
    chk("mult_wb_rd", 32'(wb_log[n0].rd), 32'd3);
    chk("mult_wb_data", wb_log[n0].data, 32'hFFFFFFD6);
    chk("mult_wb_latency", 32'(wb_log[n0].c - (a0 + 1)), 32'd18);
    chk("mult_pulses", 32'(mult_pulses), 32'd1);

    // div 100 / 0, rd=4: the unit reports an exception with status 5
    n0 = wb_log.size();
    run_op(1, 5'd4, 32'd100, 32'd0, 3, 32'h12345678, 1, 32'd5, 0, 0);
    chk("div0_wb_count", 32'(wb_log.size() - n0), 32'd1);
    chk("div0_wb_rd", 32'(wb_log[n0].rd), 32'd30);
    chk("div0_wb_data", wb_log[n0].data, 32'd5);

    // mult with rd=0: no writeback at all
    n0 = wb_log.size();
    run_op(0, 5'd0, 32'd3, 32'd4, 5, 32'd12, 0, 0, 0, 0);
    chk("rd0_no_wb", 32'(wb_log.size() - n0), 32'd0);

    // stale ready held during START, real ready 6 cycles after START
    n0 = wb_log.size();
    run_op(0, 5'd7, 32'd3, 32'd4, 6, 32'd12, 0, 0, 1, 0);
    chk("stale_wb_count", 32'(wb_log.size() - n0), 32'd1);
    chk("stale_wb_data", wb_log[n0].data, 32'd12);

    // div that never gets ready: watchdog
    n0 = wb_log.size(); a0 = cyc;
    run_op(1, 5'd9, 32'd50, 32'd5, -1, 0, 0, 0, 0, 0);
    chk("to_wb_count", 32'(wb_log.size() - n0), 32'd1);
    chk("to_wb_rd", 32'(wb_log[n0].rd), 32'd30);
    chk("to_wb_data", wb_log[n0].data, 32'd5);
    chk("to_wb_cycle", 32'(wb_log[n0].c - a0), 32'd66);
    chk("to_sticky", 32'(timeout), 32'd1);

    // reset in WAIT cycle 5: op abandoned, timeout cleared
    begin
      op_t o;
      n0 = wb_log.size();
      o.a = cyc; o.fin = cyc + 6; o.aborted = 1; o.is_div = 0; o.rd = 5'd5;
      o.opa = 32'd9; o.opb = 32'd9; o.exc = 0; o.wbd = '0; o.to = 0;
      ops.push_back(o);
      issue_valid = 1; issue_rd = 5'd5; issue_opA = 32'd9; issue_opB = 32'd9;
      step();
      issue_valid = 0;
      while (cyc < o.fin) step();
      reset = 1;
      rst_cyc.push_back(cyc);
      step();
      reset = 0;
      chk("abort_idle", 32'(busy), 32'd0);
      chk("abort_to_clr", 32'(timeout), 32'd0);
      chk("abort_no_wb", 32'(wb_log.size() - n0), 32'd0);
    end

    // back-to-back: second op issued in the IDLE cycle right after DONE
    n0 = wb_log.size();
    run_op(0, 5'd8, 32'd5, 32'd6, 2, 32'd30, 0, 0, 0, 1);
    run_op(1, 5'd10, 32'd50, 32'd7, 4, 32'd7, 0, 0, 0, 0);
    chk("b2b_wb_count", 32'(wb_log.size() - n0), 32'd2);
    chk("b2b_first", wb_log[n0].data, 32'd30);
    chk("b2b_second_rd", 32'(wb_log[n0 + 1].rd), 32'd10);
    chk("b2b_second", wb_log[n0 + 1].data, 32'd7);

    step();
    step();
    run_done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
